// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch PC sequencer.
// Owns the PC and fetch FSM (RUN / PEND / HALT). A redirect that arrives while
// fetch is blocked is parked in a pending register and applied on the first
// advancing cycle. Outputs are combinational from state and inputs, so an
// applied redirect shows up as the next cycle's iaddr.
module fetch_ctrl #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dstall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic        pc_en,
    output logic [31:0] npc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PEND = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      st;
    logic [31:0] pc;
    logic [31:0] pend_tgt;
    logic        pend_ex;

    logic [31:0] pc_nxt;
    logic [31:0] ex_tgt_al;
    logic [31:0] id_tgt_al;
    logic        pend_ex_active;
    logic        halt_take;

    // Output decode, next-PC selection and flush generation.
    always_comb begin
        ex_tgt_al      = {ex_target[31:2], 2'b00};
        id_tgt_al      = {id_target[31:2], 2'b00};
        iaddr          = pc;
        npc            = pc + 32'd4;
        iREN           = (st != S_HALT);
        halted         = (st == S_HALT);
        pc_en          = (st != S_HALT) & ihit & ~dstall;
        pend_ex_active = (st == S_PEND) & pend_ex;
        // A halt behind a live or parked EX redirect is on the wrong path.
        halt_take      = pc_en & halt & ~ex_redirect & ~pend_ex_active;
        pc_nxt         = pc + 32'd4;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        if (pc_en && !halt_take) begin
            if (ex_redirect) begin
                // A live EX redirect is older than anything parked.
                pc_nxt     = ex_tgt_al;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (st == S_PEND) begin
                pc_nxt     = pend_tgt;
                flush_ifid = 1'b1;
                flush_idex = pend_ex;
            end else if (id_redirect) begin
                pc_nxt     = id_tgt_al;
                flush_ifid = 1'b1;
            end
        end
    end

    // PC, FSM state and pending-redirect register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st       <= S_RUN;
            pc       <= PC_INIT;
            pend_tgt <= 32'd0;
            pend_ex  <= 1'b0;
        end else begin
            case (st)
                S_HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    if (halt_take) begin
                        st <= S_HALT;
                    end else if (pc_en) begin
                        pc      <= pc_nxt;
                        st      <= S_RUN;
                        pend_ex <= 1'b0;
                    end else if (ex_redirect) begin
                        pend_tgt <= ex_tgt_al;
                        pend_ex  <= 1'b1;
                        st       <= S_PEND;
                    end else if (id_redirect && !pend_ex_active) begin
                        pend_tgt <= id_tgt_al;
                        pend_ex  <= 1'b0;
                        st       <= S_PEND;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. Each step drives inputs after the falling
// edge, checks the combinational outputs before the rising edge, pushes the
// expected next PC into a scoreboard and pops it after the edge.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dstall, ex_redirect, id_redirect, halt;
    logic [31:0] ex_target, id_target;
    logic        iREN, pc_en, flush_ifid, flush_idex, halted;
    logic [31:0] iaddr, npc;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    fetch_ctrl #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dstall(dstall),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .id_redirect(id_redirect), .id_target(id_target), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .pc_en(pc_en), .npc(npc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus plus checks; called just after a falling edge.
    task automatic step(input string tag, input logic ih, input logic ds,
                        input logic exr, input logic [31:0] ext,
                        input logic idr, input logic [31:0] idt, input logic hlt,
                        input logic e_pcen, input logic e_fi, input logic e_fx,
                        input logic e_halted, input logic [31:0] e_next);
        logic [31:0] exp_pc;
        ihit = ih; dstall = ds; ex_redirect = exr; ex_target = ext;
        id_redirect = idr; id_target = idt; halt = hlt;
        #1;
        chk({tag, ".pc_en"},      {31'd0, pc_en},      {31'd0, e_pcen});
        chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, e_fi});
        chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, e_fx});
        chk({tag, ".halted"},     {31'd0, halted},     {31'd0, e_halted});
        chk({tag, ".iREN"},       {31'd0, iREN},       {31'd0, ~e_halted});
        sb_q.push_back(e_next);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, iaddr);
        end else begin
            exp_pc = sb_q.pop_front();
            chk({tag, ".iaddr"}, iaddr, exp_pc);
            chk({tag, ".npc"},   npc,   exp_pc + 32'd4);
        end
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; dstall = 1'b0; ex_redirect = 1'b0;
        id_redirect = 1'b0; halt = 1'b0; ex_target = '0; id_target = '0;
        #2;
        chk("rst.iaddr",  iaddr, 32'h0);
        chk("rst.npc",    npc,   32'h4);
        chk("rst.iREN",   {31'd0, iREN},   32'd1);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.flush",  {30'd0, flush_ifid, flush_idex}, 32'd0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        // Sequential fetch
        step("seq0", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'h4);
        step("seq1", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'h8);
        step("seq2", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'hC);
        step("seq3", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'h10);

        // Miss then ID redirect parked, applied on later hit
        step("miss0", 0,0, 0,0, 1,32'h200, 0,  0,0,0,0, 32'h10);
        step("miss1", 0,0, 0,0, 0,0,       0,  0,0,0,0, 32'h10);
        step("miss2", 1,0, 0,0, 0,0,       0,  1,1,0,0, 32'h200);

        // EX beats ID in the same cycle
        step("prio", 1,0, 1,32'h400, 1,32'h800, 0,  1,1,1,0, 32'h400);

        // Parked EX target is not overwritten by a later ID redirect
        step("pex0", 0,0, 1,32'h100, 0,0,       0,  0,0,0,0, 32'h400);
        step("pex1", 0,0, 0,0,       1,32'h300, 0,  0,0,0,0, 32'h400);
        step("pex2", 1,0, 0,0,       0,0,       0,  1,1,1,0, 32'h100);
        // Parked ID target is overwritten by EX
        step("pid0", 0,0, 0,0,       1,32'h300, 0,  0,0,0,0, 32'h100);
        step("pid1", 0,0, 1,32'h500, 0,0,       0,  0,0,0,0, 32'h100);
        step("pid2", 1,0, 0,0,       0,0,       0,  1,1,1,0, 32'h500);

        // dstall blocks advance
        step("dst0", 1,1, 0,0, 0,0, 0,  0,0,0,0, 32'h500);
        step("dst1", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'h504);

        // Live EX supersedes a parked ID target
        step("sup0", 0,0, 0,0,       1,32'h600, 0,  0,0,0,0, 32'h504);
        step("sup1", 1,0, 1,32'h700, 0,0,       0,  1,1,1,0, 32'h700);

        // Alignment and wrap
        step("align", 1,0, 0,0,            1,32'h103, 0,  1,1,0,0, 32'h100);
        step("wrap0", 1,0, 1,32'hFFFF_FFFC, 0,0,      0,  1,1,1,0, 32'hFFFF_FFFC);
        step("wrap1", 1,0, 0,0,             0,0,      0,  1,0,0,0, 32'h0);

        // Halt behind an EX redirect is ignored
        step("hex0", 1,0, 1,32'h20, 0,0, 0,  1,1,1,0, 32'h20);
        step("hex1", 1,0, 1,32'h40, 0,0, 1,  1,1,1,0, 32'h40);
        step("hex2", 1,0, 1,32'h20, 0,0, 0,  1,1,1,0, 32'h20);
        // Halt retried while blocked, taken on hit
        step("hlt0", 0,0, 0,0, 0,0, 1,  0,0,0,0, 32'h20);
        step("hlt1", 1,0, 0,0, 0,0, 1,  1,0,0,0, 32'h20);
        step("hlt2", 1,0, 1,32'h80, 0,0, 0,  0,0,0,1, 32'h20);
        step("hlt3", 1,0, 0,0, 1,32'h90, 0,  0,0,0,1, 32'h20);
        step("hlt4", 1,0, 0,0, 0,0, 0,  0,0,0,1, 32'h20);

        // Asynchronous reset out of HALT
        #2;
        nRST = 1'b0;
        #1;
        chk("arst.iaddr",  iaddr, 32'h0);
        chk("arst.halted", {31'd0, halted}, 32'd0);
        chk("arst.iREN",   {31'd0, iREN},   32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        step("post", 1,0, 0,0, 0,0, 0,  1,0,0,0, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
